// File: rtl/apb_slave_rx_buffer_pkg.sv
// Constants and types shared between apb_interconnect and its per-slave rx buffers.
// Widths fixed at the interconnect defaults.
package apb_ic_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_SOURCES = 8;
  localparam int ADDR_WIDTH  = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [NUM_SOURCES-1:0] src_mask_t;

endpackage

// File: rtl/apb_slave_rx_buffer_if.sv
// Interconnect-side strobes/data plus the consumer valid/ready pop port.
// The master modport is the environment, the slave modport is the buffer.
interface apb_slave_rx_buffer_if;
  import apb_ic_pkg::*;

  data_t     slave_data;
  src_mask_t slave_valids;
  logic      brdcst_subscribe;
  data_t     rd_data;
  logic      rd_valid;
  logic      rd_ready;

  modport master (
    output slave_data, slave_valids, rd_ready,
    input  brdcst_subscribe, rd_data, rd_valid
  );

  modport slave (
    input  slave_data, slave_valids, rd_ready,
    output brdcst_subscribe, rd_data, rd_valid
  );
endinterface

// File: rtl/apb_rx_fifo_ram.sv
// DEPTH x DATA_WIDTH storage for the rx buffer.
// Synchronous write, asynchronous read.
module apb_rx_fifo_ram
  import apb_ic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  data_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output data_t         rd_data
);

  data_t mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apb_slave_rx_buffer.sv
// Per-slave ingress FIFO absorbing interconnect strobes, with auto broadcast unsubscribe.
// Optional APB_RX_DROP_CNT_EN adds a saturating 16-bit dropped-word counter.
module apb_slave_rx_buffer
  import apb_ic_pkg::*;
#(
  parameter int SLAVE_ID = 0,
  parameter int DEPTH    = 8
) (
  input  logic                       pclk,
  input  logic                       reset,
  apb_slave_rx_buffer_if.slave       bus,
  input  logic                       brdcst_req,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  input  logic                       ovf_clr,
  output logic                       overflow
`ifdef APB_RX_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [FW-1:0] fill_nxt;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  data_t         ram_head;
  data_t         head_nxt;

  assign push   = bus.slave_valids[SLAVE_ID];
  assign full   = fill_level == FW'(DEPTH);
  assign pop    = bus.rd_valid & bus.rd_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign fill_nxt   = fill_level + FW'(accept) - FW'(pop);

  assign bus.rd_valid = fill_level != '0;

  apb_rx_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .pclk    (pclk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.slave_data),
    .rd_addr (rd_ptr_nxt),
    .rd_data (ram_head)
  );

  // A word written into an otherwise-empty queue becomes the head this edge.
  assign head_nxt = (accept && wr_ptr == rd_ptr_nxt) ?
                    bus.slave_data : ram_head;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fill_level           <= '0;
      bus.rd_data          <= '0;
      overflow             <= 1'b0;
      bus.brdcst_subscribe <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr               <= rd_ptr_nxt;
      fill_level           <= fill_nxt;
      bus.rd_data          <= head_nxt;
      overflow             <= drop | (overflow & ~ovf_clr);
      bus.brdcst_subscribe <= brdcst_req &
                              (fill_nxt < FW'(DEPTH-1));
    end
  end

`ifdef APB_RX_DROP_CNT_EN
  always_ff @(posedge pclk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= {15'd0, drop};
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_apb_slave_rx_buffer.sv
// Self-checking bench for apb_slave_rx_buffer (SLAVE_ID=2, DEPTH=8).
// Queue-based reference model plus vector table and directed corner sequences.
module tb_apb_slave_rx_buffer;
  import apb_ic_pkg::*;

  localparam int SID   = 2;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        brdcst_req;
  logic        ovf_clr;
  logic [3:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_cnt;

  apb_slave_rx_buffer_if bus ();

  apb_slave_rx_buffer #(
    .SLAVE_ID (SID),
    .DEPTH    (DEPTH)
  ) dut (
    .pclk       (clk),
    .reset      (rst_n),
    .bus        (bus),
    .brdcst_req (brdcst_req),
    .fill_level (fill_level),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow)
`ifdef APB_RX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

`ifndef APB_RX_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;

  data_t mq[$];
  bit    m_ovf;
  int    m_dc;
  bit    m_sub;

  typedef struct {
    bit          rn;
    logic [7:0]  v;
    logic [31:0] d;
    bit          rdy;
    int          e_fill;
    bit          e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input logic [7:0] v, input logic [31:0] d,
                      input bit rdy, input bit req, input bit clr);
    bit push;
    bit pop;
    bit drop;
    rst_n            = rn;
    bus.slave_valids = v;
    bus.slave_data   = d;
    bus.rd_ready     = rdy;
    brdcst_req       = req;
    ovf_clr          = clr;
    push = v[SID];
    pop  = (mq.size() != 0) && rdy;
    drop = push && (mq.size() == DEPTH) && !pop;
    if (!rn) begin
      mq.delete();
      m_ovf = 0;
      m_dc  = 0;
      m_sub = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(d);
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (clr) m_dc = drop ? 1 : 0;
      else if (drop && m_dc < 65535) m_dc++;
      m_sub = req && (mq.size() < DEPTH - 1);
    end
    @(posedge clk);
    #1;
    chk("fill", fill_level, mq.size());
    chk("valid", bus.rd_valid, mq.size() != 0);
    if (mq.size() != 0) chk("data", bus.rd_data, mq[0]);
    else if (!rn) chk("rst_data", bus.rd_data, 0);
    chk("ovf", overflow, m_ovf);
    chk("sub", bus.brdcst_subscribe, m_sub);
`ifdef APB_RX_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, m_dc);
`endif
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n = 0; bus.slave_valids = '0; bus.slave_data = '0;
    bus.rd_ready = 0; brdcst_req = 0; ovf_clr = 0;

    // reset held with strobes active
    for (int i = 0; i < 3; i++) step(0, 8'hFF, 32'h1234_5678, 1, 1, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sub", bus.brdcst_subscribe, 0);
    chk("rst_rdata", bus.rd_data, 0);

    // vector table: own strobe, foreign strobe, push&pop
    tbl[0] = '{0, 8'h00, 32'h0,         0, 0, 0, 32'h0};
    tbl[1] = '{1, 8'h04, 32'hA5A5_0001, 0, 1, 1, 32'hA5A5_0001};
    tbl[2] = '{1, 8'h08, 32'hDEAD_BEEF, 0, 1, 1, 32'hA5A5_0001};
    tbl[3] = '{1, 8'h04, 32'h0000_0002, 0, 2, 1, 32'hA5A5_0001};
    tbl[4] = '{1, 8'h00, 32'h0,         1, 1, 1, 32'h0000_0002};
    tbl[5] = '{1, 8'h04, 32'h0000_0003, 1, 1, 1, 32'h0000_0003};
    tbl[6] = '{1, 8'hFF, 32'h0000_0004, 1, 1, 1, 32'h0000_0004};
    tbl[7] = '{1, 8'h00, 32'h0,         1, 0, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rn, tbl[i].v, tbl[i].d, tbl[i].rdy, 0, 0);
      chk("tbl_fill", fill_level, tbl[i].e_fill);
      chk("tbl_valid", bus.rd_valid, tbl[i].e_valid);
      if (tbl[i].e_valid || !tbl[i].rn) chk("tbl_data", bus.rd_data, tbl[i].e_data);
    end

    // fill to overflow with broadcast requested
    for (int i = 0; i < 9; i++) begin
      step(1, 8'h04, 32'h100 + i, 0, 1, 0);
      if (i == 5) chk("sub_at6", bus.brdcst_subscribe, 1);
      if (i == 6) chk("sub_at7", bus.brdcst_subscribe, 0);
    end
    chk("full_fill", fill_level, 8);
    chk("full_ovf", overflow, 1);
    chk("full_head", bus.rd_data, 32'h100);
`ifdef APB_RX_DROP_CNT_EN
    chk("full_dc", drop_cnt, 1);
`endif

    // full + push + pop: no drop, order kept
    step(1, 8'h04, 32'h200, 1, 1, 0);
    chk("fpp_fill", fill_level, 8);
    chk("fpp_head", bus.rd_data, 32'h101);
`ifdef APB_RX_DROP_CNT_EN
    chk("fpp_dc", drop_cnt, 1);
`endif

    // clear coinciding with a drop: set wins
    step(1, 8'h04, 32'h300, 0, 1, 1);
    chk("clr_drop_ovf", overflow, 1);
`ifdef APB_RX_DROP_CNT_EN
    chk("clr_drop_dc", drop_cnt, 1);
`endif
    step(1, 8'h00, 32'h0, 0, 1, 1);
    chk("clr_ovf", overflow, 0);

    for (int i = 0; i < 8; i++) begin
      chk("drain_order", bus.rd_data, (i < 7) ? 32'h101 + i : 32'h200);
      step(1, 8'h00, 32'h0, 1, 1, 0);
    end
    chk("drained", fill_level, 0);
    chk("resub", bus.brdcst_subscribe, 1);

    // continuous stream through the wrap
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h04, 32'h400 + i, 1, 0, 0);
      chk("stream_data", bus.rd_data, 32'h400 + i);
      chk("stream_fill", fill_level, 1);
    end
    step(1, 8'h00, 32'h0, 1, 0, 0);
    chk("stream_ovf", overflow, 0);

    // reset while half full
    for (int i = 0; i < 4; i++) step(1, 8'h04, 32'h500 + i, 0, 0, 0);
    step(0, 8'h04, 32'h600, 0, 0, 0);
    chk("midrst_fill", fill_level, 0);
    chk("midrst_valid", bus.rd_valid, 0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [7:0] v;
      v      = 8'($urandom);
      v[SID] = ($urandom_range(99) < 60);
      step($urandom_range(199) != 0, v, $urandom,
           $urandom_range(99) < 45, $urandom_range(99) < 80,
           $urandom_range(99) < 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
